// File: rtl/fetch_pc_sequencer_if.sv
// Fetch request port between BPU/backend control and the IFU input.
// The master side drives redirect/idle/BPU/ready; the slave (sequencer) drives the request.
interface fetch_pc_sequencer_if;
   logic        bk_redirect_valid;
   logic [31:0] bk_redirect_pc;
   logic        idle_req;
   logic        wake;
   logic        bpu_pred_taken;
   logic [1:0]  bpu_pred_slot;
   logic [31:0] bpu_target_pc;
   logic        ifu_ready;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [1:0]  cut_pos;
   logic        pred_taken;
   logic [31:0] pred_jump_target_pc;
   logic        flush_ifu;

   modport master (
      output bk_redirect_valid, bk_redirect_pc, idle_req, wake,
             bpu_pred_taken, bpu_pred_slot, bpu_target_pc, ifu_ready,
      input  fetch_valid, fetch_pc, cut_pos, pred_taken, pred_jump_target_pc, flush_ifu
   );

   modport slave (
      input  bk_redirect_valid, bk_redirect_pc, idle_req, wake,
             bpu_pred_taken, bpu_pred_slot, bpu_target_pc, ifu_ready,
      output fetch_valid, fetch_pc, cut_pos, pred_taken, pred_jump_target_pc, flush_ifu
   );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: holds the fetch PC, emits one 16B-block request per cycle in RUN,
// and handles backend redirects, post-redirect bubbles and idle/wake.
module fetch_pc_sequencer #(
   parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
   parameter int unsigned REDIRECT_BUBBLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fetch_pc_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {BOOT, RUN, BUBBLE, IDLE} state_t;

   localparam logic [2:0] BUBBLE_INIT = 3'(REDIRECT_BUBBLE - 1);

   state_t      state;
   logic [31:0] pc_q;
   logic [2:0]  bubble_cnt;

   logic [1:0]  s0;
   logic        fetch_valid;
   logic        use_pred;
   logic        xfer;
   logic [31:0] seq_pc;

   assign s0          = pc_q[3:2];
   assign fetch_valid = (state == RUN) && !bus.bk_redirect_valid;
   // A taken branch in a slot before the entry slot belongs to a previous pass over this block.
   assign use_pred    = fetch_valid && bus.bpu_pred_taken && (bus.bpu_pred_slot >= s0);
   assign xfer        = fetch_valid && bus.ifu_ready;
   assign seq_pc      = {pc_q[31:4] + 28'd1, 4'b0000};

   assign bus.fetch_valid         = fetch_valid;
   assign bus.fetch_pc            = pc_q;
   assign bus.cut_pos             = use_pred ? 2'(bus.bpu_pred_slot - s0 + 2'd1) : 2'(2'd0 - s0);
   assign bus.pred_taken          = use_pred;
   assign bus.pred_jump_target_pc = use_pred ? bus.bpu_target_pc : 32'h0;
   assign bus.flush_ifu           = bus.bk_redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         pc_q       <= RESET_PC;
         bubble_cnt <= 3'd0;
      end else if (bus.bk_redirect_valid) begin
         state      <= BUBBLE;
         pc_q       <= {bus.bk_redirect_pc[31:2], 2'b00};
         bubble_cnt <= BUBBLE_INIT;
      end else begin
         case (state)
            BOOT: state <= RUN;
            RUN: begin
               if (xfer)
                  pc_q <= use_pred ? {bus.bpu_target_pc[31:2], 2'b00} : seq_pc;
               if (bus.idle_req)
                  state <= IDLE;
            end
            BUBBLE: begin
               if (bubble_cnt == 3'd0) state <= RUN;
               else                    bubble_cnt <= bubble_cnt - 3'd1;
            end
            IDLE: if (bus.wake) state <= RUN;
            default: state <= BOOT;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer with a scoreboard of expected fetch transfers.
module tb_fetch_pc_sequencer;
   typedef struct packed {
      logic [31:0] pc;
      logic [1:0]  cut;
      logic        pt;
      logic [31:0] tgt;
   } req_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_asrt = 0;
   int   n_fail = 0;
   req_t sb_q[$];

   fetch_pc_sequencer_if bus ();

   fetch_pc_sequencer #(.RESET_PC(32'h1C00_0000), .REDIRECT_BUBBLE(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [1:0] cut, input logic pt, input logic [31:0] tgt);
      req_t r;
      r.pc = pc; r.cut = cut; r.pt = pt; r.tgt = tgt;
      sb_q.push_back(r);
   endtask

   // Sample mid-cycle; any transfer seen must match the oldest expected request.
   task automatic sample();
      req_t r;
      @(negedge clk);
      if (bus.fetch_valid && bus.ifu_ready) begin
         chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            r = sb_q.pop_front();
            chk("xfer_pc",  bus.fetch_pc, r.pc);
            chk("xfer_cut", 32'(bus.cut_pos), 32'(r.cut));
            chk("xfer_pt",  32'(bus.pred_taken), 32'(r.pt));
            chk("xfer_tgt", bus.pred_jump_target_pc, r.tgt);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      bus.bk_redirect_valid = 1'b1;
      bus.bk_redirect_pc    = pc;
      sample();
      chk("redir_flush", 32'(bus.flush_ifu), 32'd1);
      chk("redir_valid", 32'(bus.fetch_valid), 32'd0);
      adv();
      bus.bk_redirect_valid = 1'b0;
      sample();
      chk("bubble_valid", 32'(bus.fetch_valid), 32'd0);
      chk("bubble_flush", 32'(bus.flush_ifu), 32'd0);
      adv();
   endtask

   initial begin
      bus.bk_redirect_valid = 1'b0;
      bus.bk_redirect_pc    = 32'h0;
      bus.idle_req          = 1'b0;
      bus.wake              = 1'b0;
      bus.bpu_pred_taken    = 1'b0;
      bus.bpu_pred_slot     = 2'd0;
      bus.bpu_target_pc     = 32'h0;
      bus.ifu_ready         = 1'b1;

      // reset values
      sample();
      chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
      chk("rst_pt",    32'(bus.pred_taken), 32'd0);
      chk("rst_tgt",   bus.pred_jump_target_pc, 32'h0);
      chk("rst_flush", 32'(bus.flush_ifu), 32'd0);
      chk("rst_pc",    bus.fetch_pc, 32'h1C00_0000);
      adv();
      rst_n = 1'b1;
      sample();
      chk("boot_valid", 32'(bus.fetch_valid), 32'd0);
      adv();
      push(32'h1C00_0000, 2'b00, 1'b0, 32'h0);
      sample();
      chk("run_valid", 32'(bus.fetch_valid), 32'd1);
      adv();
      push(32'h1C00_0010, 2'b00, 1'b0, 32'h0); sample(); adv();

      // sequential from a mid-block entry
      redirect(32'h1C00_0008);
      push(32'h1C00_0008, 2'b10, 1'b0, 32'h0); sample(); adv();
      push(32'h1C00_0010, 2'b00, 1'b0, 32'h0); sample(); adv();

      // sequential wrap
      redirect(32'hFFFF_FFF0);
      push(32'hFFFF_FFF0, 2'b00, 1'b0, 32'h0); sample(); adv();
      push(32'h0000_0000, 2'b00, 1'b0, 32'h0); sample(); adv();

      // taken prediction used
      redirect(32'h1C00_0004);
      bus.bpu_pred_taken = 1'b1; bus.bpu_pred_slot = 2'd2; bus.bpu_target_pc = 32'h1C00_0100;
      push(32'h1C00_0004, 2'b10, 1'b1, 32'h1C00_0100); sample(); adv();
      bus.bpu_pred_taken = 1'b0;
      push(32'h1C00_0100, 2'b00, 1'b0, 32'h0); sample(); adv();

      // taken prediction in a slot before entry: ignored
      redirect(32'h1C00_0004);
      bus.bpu_pred_taken = 1'b1; bus.bpu_pred_slot = 2'd0; bus.bpu_target_pc = 32'h1C00_0100;
      push(32'h1C00_0004, 2'b11, 1'b0, 32'h0); sample(); adv();
      bus.bpu_pred_taken = 1'b0;
      push(32'h1C00_0010, 2'b00, 1'b0, 32'h0); sample(); adv();

      // taken in the last slot from slot 0: full block, unaligned target forced aligned
      bus.bpu_pred_taken = 1'b1; bus.bpu_pred_slot = 2'd3; bus.bpu_target_pc = 32'h1C00_0333;
      push(32'h1C00_0020, 2'b00, 1'b1, 32'h1C00_0333); sample(); adv();
      bus.bpu_pred_taken = 1'b0;
      push(32'h1C00_0330, 2'b00, 1'b0, 32'h0); sample(); adv();

      // backpressure: request held stable
      bus.ifu_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample();
         chk("stall_valid", 32'(bus.fetch_valid), 32'd1);
         chk("stall_pc",    bus.fetch_pc, 32'h1C00_0340);
         chk("stall_cut",   32'(bus.cut_pos), 32'd0);
         adv();
      end
      bus.ifu_ready = 1'b1;
      push(32'h1C00_0340, 2'b00, 1'b0, 32'h0); sample(); adv();

      // redirect with unaligned target
      redirect(32'h1C00_0203);
      push(32'h1C00_0200, 2'b00, 1'b0, 32'h0); sample(); adv();

      // idle, then wake 10 cycles later
      bus.idle_req = 1'b1;
      push(32'h1C00_0210, 2'b00, 1'b0, 32'h0); sample(); adv();
      bus.idle_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.wake = (i == 9);
         sample();
         chk("idle_valid", 32'(bus.fetch_valid), 32'd0);
         chk("idle_pc",    bus.fetch_pc, 32'h1C00_0220);
         adv();
      end
      bus.wake = 1'b0;
      push(32'h1C00_0220, 2'b00, 1'b0, 32'h0); sample(); adv();

      // idle, then redirect and wake together: redirect wins
      bus.idle_req = 1'b1;
      push(32'h1C00_0230, 2'b00, 1'b0, 32'h0); sample(); adv();
      bus.idle_req = 1'b0;
      sample();
      chk("idle2_valid", 32'(bus.fetch_valid), 32'd0);
      adv();
      bus.wake = 1'b1;
      redirect(32'h1C00_0500);
      bus.wake = 1'b0;
      push(32'h1C00_0500, 2'b00, 1'b0, 32'h0); sample(); adv();

      // reset mid-operation
      rst_n = 1'b0;
      sample();
      chk("mrst_valid", 32'(bus.fetch_valid), 32'd0);
      chk("mrst_pc",    bus.fetch_pc, 32'h1C00_0000);
      adv();
      rst_n = 1'b1;
      sample();
      chk("mrst_boot", 32'(bus.fetch_valid), 32'd0);
      adv();
      push(32'h1C00_0000, 2'b00, 1'b0, 32'h0); sample(); adv();

      bus.ifu_ready = 1'b0;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
